// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite types for the register slave.
// Contents:
//   axi4l_resp_t   - response encoding carried on bresp/rresp
//   wr_state_t     - write-channel FSM states
//   rd_state_t     - read-channel FSM states
//   axi4l_addr_lsb - number of byte-offset address bits for a data width
package axi4l_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi4l_resp_t;

    typedef enum logic {
        WR_COLLECT = 1'b0,
        WR_RESP    = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    function automatic int axi4l_addr_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/axi4l_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS read/write registers.
// Ports:
//   axi4l_aclk, axi4l_arst        - clock, async active-high reset
//   s_aw*/s_w*/s_b*               - write address, data and response channels
//   s_ar*/s_r*                    - read address and data channels
//   reg_q                         - flat register contents, reg i at [i*DW +: DW]
//   reg_wr_pulse                  - one-cycle pulse per register on an OKAY write
// Handshake rule: a beat transfers on a rising edge where valid and ready are
// both high; a source holds valid and payload stable until that edge.
// FSM state is visible hierarchically as wr_state_q / rd_state_q.
module axi4l_reg_slave
    import axi4l_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           axi4l_aclk,
    input  logic                           axi4l_arst,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int ADDR_LSB = axi4l_addr_lsb(DATA_WIDTH);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic [DATA_WIDTH-1:0] strb_merge(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    logic                  rst_done_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    wr_state_t             wr_state_q, wr_state_d;
    logic                  aw_held_q, w_held_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  bvalid_q;
    axi4l_resp_t           bresp_q;
    logic [NUM_REGS-1:0]   wr_pulse_q;

    rd_state_t             rd_state_q, rd_state_d;
    logic                  rvalid_q;
    axi4l_resp_t           rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Handshakes are formed from flops and inputs only, so the ready
    // outputs below never feed back into their own decode.
    logic aw_hs, w_hs, ar_hs, wr_commit;
    assign aw_hs     = s_awvalid & rst_done_q & ~aw_held_q & (wr_state_q == WR_COLLECT);
    assign w_hs      = s_wvalid  & rst_done_q & ~w_held_q  & (wr_state_q == WR_COLLECT);
    assign ar_hs     = s_arvalid & rst_done_q & (rd_state_q == RD_IDLE);
    assign wr_commit = (aw_held_q | aw_hs) & (w_held_q | w_hs);

    // A held beat takes priority over the live bus value.
    logic [ADDR_WIDTH-1:0] wr_addr, wr_idx_full, rd_idx_full;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_in_range, rd_in_range;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    assign wr_addr     = aw_held_q ? awaddr_q : s_awaddr;
    assign wr_data     = w_held_q  ? wdata_q  : s_wdata;
    assign wr_strb     = w_held_q  ? wstrb_q  : s_wstrb;
    assign wr_idx_full = wr_addr  >> ADDR_LSB;
    assign rd_idx_full = s_araddr >> ADDR_LSB;
    assign wr_in_range = wr_idx_full < ADDR_WIDTH'(NUM_REGS);
    assign rd_in_range = rd_idx_full < ADDR_WIDTH'(NUM_REGS);
    assign wr_idx      = wr_idx_full[IDX_W-1:0];
    assign rd_idx      = rd_idx_full[IDX_W-1:0];

    // Readys stay low until the first edge after reset release.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
        if (axi4l_arst) rst_done_q <= 1'b0;
        else            rst_done_q <= 1'b1;
    end

    // ---------------- write FSM ----------------
    always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
        if (axi4l_arst) wr_state_q <= WR_COLLECT;
        else            wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        case (wr_state_q)
            WR_COLLECT: begin
                s_awready = rst_done_q & ~aw_held_q;
                s_wready  = rst_done_q & ~w_held_q;
                if (wr_commit) wr_state_d = WR_RESP;
            end
            WR_RESP: begin
                if (s_bready) wr_state_d = WR_COLLECT;
            end
            default: wr_state_d = WR_COLLECT;
        endcase
    end

    always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
        if (axi4l_arst) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= '0;
            if (wr_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_in_range ? OKAY : SLVERR;
                if (wr_in_range) wr_pulse_q[wr_idx] <= 1'b1;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    awaddr_q  <= s_awaddr;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= s_wdata;
                    wstrb_q  <= s_wstrb;
                end
                if (bvalid_q && s_bready) bvalid_q <= 1'b0;
            end
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
        if (axi4l_arst) rd_state_q <= RD_IDLE;
        else            rd_state_q <= rd_state_d;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        s_arready  = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                s_arready = rst_done_q;
                if (ar_hs) rd_state_d = RD_RESP;
            end
            RD_RESP: begin
                if (s_rready) rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // rdata samples regs_q before any same-edge write lands, so a colliding
    // read returns the pre-write value.
    always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
        if (axi4l_arst) begin
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= rd_in_range ? OKAY : SLVERR;
            rdata_q  <= rd_in_range ? regs_q[rd_idx] : '0;
        end else if (rvalid_q && s_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    // ---------------- register array ----------------
    always_ff @(posedge axi4l_aclk or posedge axi4l_arst) begin
        if (axi4l_arst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else if (wr_commit && wr_in_range) begin
            regs_q[wr_idx] <= strb_merge(regs_q[wr_idx], wr_data, wr_strb);
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign s_bvalid     = bvalid_q;
    assign s_bresp      = bresp_q;
    assign s_rvalid     = rvalid_q;
    assign s_rresp      = rresp_q;
    assign s_rdata      = rdata_q;
    assign reg_wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_axi4l_reg_slave.sv
// Bench for axi4l_reg_slave: directed steps followed by randomized register
// traffic, checked against an array model of the register file.
module tb_axi4l_reg_slave;

    localparam int          NR   = 16;
    localparam logic [31:0] RVAL = 32'hDEAD_0000;
    localparam logic [1:0]  R_OK = 2'b00;
    localparam logic [1:0]  R_SE = 2'b10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [31:0]     s_awaddr = '0;
    logic            s_awvalid = 1'b0;
    logic            s_awready;
    logic [31:0]     s_wdata = '0;
    logic [3:0]      s_wstrb = '0;
    logic            s_wvalid = 1'b0;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready = 1'b0;
    logic [31:0]     s_araddr = '0;
    logic            s_arvalid = 1'b0;
    logic            s_arready;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready = 1'b0;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0]   reg_wr_pulse;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_regs [NR];

    always #5 clk = ~clk;

    axi4l_reg_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(NR), .RESET_VAL(RVAL)
    ) dut (
        .axi4l_aclk(clk), .axi4l_arst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    task automatic chk(input string tag, input logic [NR*32-1:0] obs, input logic [NR*32-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = exp_regs[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) exp_regs[i] = RVAL;
    endtask

    // Full write transaction; AW and W valids rise after their own delays,
    // the response is left unacknowledged for b_dly cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        int          idx;
        bit          in_rng, aw_done, w_done;
        int          cyc;
        logic [1:0]  exp_resp;
        logic [NR-1:0] exp_pulse;
        idx       = int'(addr >> 2);
        in_rng    = (idx < NR);
        exp_resp  = in_rng ? R_OK : R_SE;
        exp_pulse = '0;
        if (in_rng) begin
            exp_pulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (strb[b]) exp_regs[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        aw_done = 0; w_done = 0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 40) begin
            if (aw_done) chk("awready_while_held", s_awready, 0);
            if (w_done)  chk("wready_while_held", s_wready, 0);
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_wvalid  = !w_done  && (cyc >= w_dly);
            if (s_awvalid && s_awready) aw_done = 1;
            if (s_wvalid && s_wready)   w_done  = 1;
            @(negedge clk);
            cyc++;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk("wr_accept_timeout", aw_done && w_done, 1);
        chk("bvalid_after_commit", s_bvalid, 1);
        chk("bresp", s_bresp, exp_resp);
        chk("wr_pulse", reg_wr_pulse, exp_pulse);
        chk("reg_q_after_write", reg_q, model_flat());
        for (int k = 0; k < b_dly; k++) begin
            s_bready = 1'b0;
            @(negedge clk);
            chk("bvalid_hold", s_bvalid, 1);
            chk("bresp_hold", s_bresp, exp_resp);
            chk("awready_in_resp", {s_awready, s_wready}, 0);
            chk("pulse_one_cycle", reg_wr_pulse, 0);
        end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        chk("bvalid_clear", s_bvalid, 0);
        chk("pulse_after_resp", reg_wr_pulse, 0);
        chk("ready_after_resp", {s_awready, s_wready}, 2'b11);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly);
        int          idx, cyc;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        idx      = int'(addr >> 2);
        exp_data = (idx < NR) ? exp_regs[idx] : 32'h0;
        exp_resp = (idx < NR) ? R_OK : R_SE;
        s_araddr = addr; s_arvalid = 1'b1; cyc = 0;
        while (!s_arready && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("ar_accept_timeout", s_arready, 1);
        @(negedge clk);
        s_arvalid = 1'b0;
        chk("rvalid", s_rvalid, 1);
        chk("rdata", s_rdata, exp_data);
        chk("rresp", s_rresp, exp_resp);
        for (int k = 0; k < r_dly; k++) begin
            s_rready = 1'b0;
            @(negedge clk);
            chk("rvalid_hold", s_rvalid, 1);
            chk("rdata_hold", s_rdata, exp_data);
            chk("arready_in_resp", s_arready, 0);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        chk("rvalid_clear", s_rvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, d;
        logic [31:0] old1;

        // Step 1: reset state and release.
        model_reset();
        #12;
        chk("rst_readys", {s_awready, s_wready, s_arready}, 0);
        chk("rst_valids", {s_bvalid, s_rvalid}, 0);
        chk("rst_pulse", reg_wr_pulse, 0);
        chk("rst_regs", reg_q, model_flat());
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release_readys", {s_awready, s_wready, s_arready}, 0);
        @(negedge clk);
        chk("post_release_readys", {s_awready, s_wready, s_arready}, 3'b111);
        do_read(32'h00, 0);

        // Step 2: AW and W together.
        do_write(32'h08, 32'h1234_5678, 4'hF, 0, 0, 0);
        do_read(32'h08, 1);

        // Step 3: W first, AW three cycles later, slow bready.
        do_write(32'h0C, 32'hCAFE_F00D, 4'hF, 3, 0, 4);
        do_read(32'h0C, 0);

        // Step 4: partial strobes.
        do_write(32'h04, 32'hAABB_CCDD, 4'hF, 0, 1, 0);
        do_write(32'h04, 32'h1122_3344, 4'b0101, 1, 0, 1);
        do_read(32'h04, 0);
        chk("strb_merge_const", reg_q[1*32 +: 32], 32'hAA22_CC44);
        do_write(32'h04, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0);

        // Step 5: out-of-range write and read.
        do_write(32'h40, 32'h5555_5555, 4'hF, 0, 0, 2);
        do_read(32'h40, 1);

        // Same-edge read and write on one register: read sees the old value.
        old1 = exp_regs[1];
        s_awaddr = 32'h04; s_wdata = 32'h5555_6666; s_wstrb = 4'hF; s_araddr = 32'h04;
        s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        exp_regs[1] = 32'h5555_6666;
        chk("coll_rvalid", s_rvalid, 1);
        chk("coll_rdata_old", s_rdata, old1);
        chk("coll_bvalid", s_bvalid, 1);
        chk("coll_regs", reg_q, model_flat());
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        chk("coll_done", {s_bvalid, s_rvalid}, 0);

        // Randomized traffic, some of it outside the register window.
        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 1)
                do_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end
        chk("random_final_regs", reg_q, model_flat());

        // Step 6: reset with a held W beat and a pending read response.
        s_wdata = 32'hBAD0_BAD0; s_wstrb = 4'hF; s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        chk("w_held_wready", s_wready, 0);
        s_araddr = 32'h00; s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        chk("pre_rst_rvalid", s_rvalid, 1);
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_valids", {s_bvalid, s_rvalid}, 0);
        chk("midrst_readys", {s_awready, s_wready, s_arready}, 0);
        chk("midrst_regs", reg_q, model_flat());
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_write(32'h10, 32'h0F0F_1234, 4'hF, 0, 0, 0);
        do_read(32'h10, 0);
        do_read(32'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
